// File: rtl/branch_predictor.sv
// Next-fetch-address generator: JAL/JALR targets plus static or 2-bit-counter
// conditional-branch prediction, with saturating branch/mispredict statistics.
package bp_pkg;
   localparam logic [1:0] TGT_NONE = 2'd0;
   localparam logic [1:0] TGT_JAL  = 2'd1;
   localparam logic [1:0] TGT_JALR = 2'd2;
   localparam logic [1:0] TGT_BR   = 2'd3;
endpackage

module branch_predictor
   import bp_pkg::*;
#(
   parameter int         IDX_BITS   = 6,
   parameter int         MODE       = 1,
   parameter logic [1:0] INIT_STATE = 2'b01,
   parameter int         STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pred_valid,
   input  logic [31:0]           pred_pc,
   input  logic [1:0]            pred_sel,
   input  logic [31:0]           pred_rd1,
   input  logic [31:0]           pred_imm,
   output logic [31:0]           target,
   output logic                  target_taken,
   input  logic                  upd_valid,
   input  logic [31:0]           upd_pc,
   input  logic                  upd_taken,
   input  logic                  upd_mispredict,
   output logic [STAT_WIDTH-1:0] br_count,
   output logic [STAT_WIDTH-1:0] mispredict_count
);

   localparam int                    ENTRIES  = 1 << IDX_BITS;
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
   localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

   logic [1:0]            pht_q [ENTRIES];
   logic [1:0]            pht_d [ENTRIES];
   logic [STAT_WIDTH-1:0] br_count_q, br_count_d;
   logic [STAT_WIDTH-1:0] mis_count_q, mis_count_d;
   logic [IDX_BITS-1:0]   pred_idx, upd_idx;
   logic [31:0]           seq_pc, rel_pc, ind_pc;
   logic                  br_taken;
   logic                  unused_upd_pc_bits;

   assign pred_idx = pred_pc[IDX_BITS+1:2];
   assign upd_idx  = upd_pc[IDX_BITS+1:2];
   assign seq_pc   = pred_pc + 32'd4;
   assign rel_pc   = pred_pc + pred_imm;
   assign ind_pc   = (pred_rd1 + pred_imm) & ~32'h1;
   assign unused_upd_pc_bits = ^{upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

   // Static mode predicts backward branches taken; dynamic mode reads the counter MSB.
   assign br_taken = (MODE == 0) ? pred_imm[31] : pht_q[pred_idx][1];

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      target       = seq_pc;
      target_taken = 1'b0;
      if (pred_valid) begin
         case (pred_sel)
            TGT_JAL: begin
               target       = rel_pc;
               target_taken = 1'b1;
            end
            TGT_JALR: begin
               target       = ind_pc;
               target_taken = 1'b1;
            end
            TGT_BR: begin
               if (br_taken) begin
                  target       = rel_pc;
                  target_taken = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pht_d = pht_q;
      if (MODE != 0 && upd_valid) begin
         if (upd_taken) begin
            if (pht_q[upd_idx] != 2'b11) pht_d[upd_idx] = pht_q[upd_idx] + 2'b01;
         end else begin
            if (pht_q[upd_idx] != 2'b00) pht_d[upd_idx] = pht_q[upd_idx] - 2'b01;
         end
      end
   end

   always_comb begin
      br_count_d  = br_count_q;
      mis_count_d = mis_count_q;
      if (upd_valid) begin
         if (br_count_q != STAT_MAX) br_count_d = br_count_q + STAT_ONE;
         if (upd_mispredict && mis_count_q != STAT_MAX) mis_count_d = mis_count_q + STAT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the table is built from flops and every entry is reset, because
         // predictions right after reset must read INIT_STATE, never X.
         for (int i = 0; i < ENTRIES; i++) pht_q[i] <= INIT_STATE;
         br_count_q  <= '0;
         mis_count_q <= '0;
      end else begin
         pht_q       <= pht_d;
         br_count_q  <= br_count_d;
         mis_count_q <= mis_count_d;
      end
   end

   assign br_count         = br_count_q;
   assign mispredict_count = mis_count_q;

endmodule
